// File: rtl/wb_regfile.sv
// Write-back sink: commits MEM/WB results to the GPR file and HI/LO,
// with same-cycle bypass to the read ports and a retirement counter.
module wb_regfile #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       wb_wd,
    input  logic             wb_wreg,
    input  logic [31:0]      wb_wdata,
    input  logic [31:0]      wb_hi,
    input  logic [31:0]      wb_lo,
    input  logic             wb_whilo,
    input  logic             re1,
    input  logic [4:0]       raddr1,
    output logic [31:0]      rdata1,
    input  logic             re2,
    input  logic [4:0]       raddr2,
    output logic [31:0]      rdata2,
    output logic [31:0]      hi_o,
    output logic [31:0]      lo_o,
    output logic [CNT_W-1:0] retire_cnt,
    input  logic             cnt_clr
);

    logic [31:0] regs [NUM_REGS];
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        gpr_we;
    logic        commit;

    // r0 is never stored, so a write to it is dropped here.
    assign gpr_we = wb_wreg && (wb_wd != 5'd0);
    assign commit = gpr_we || wb_whilo;

    // GPR storage; r0 stays zero because gpr_we excludes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (gpr_we) begin
            regs[wb_wd] <= wb_wdata;
        end
    end

    // HI/LO pair, always written together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    // Retirement counter: one count per committing cycle, clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= '0;
        end else if (cnt_clr) begin
            retire_cnt <= '0;
        end else if (commit) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

    // Read port 1 with write-back bypass.
    always_comb begin
        rdata1 = '0;
        if (!rst) begin
            rdata1 = '0;
        end else if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if (re1 && wb_wreg && (raddr1 == wb_wd)) begin
            rdata1 = wb_wdata;
        end else if (re1) begin
            rdata1 = regs[raddr1];
        end
    end

    // Read port 2 with write-back bypass.
    always_comb begin
        rdata2 = '0;
        if (!rst) begin
            rdata2 = '0;
        end else if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else if (re2 && wb_wreg && (raddr2 == wb_wd)) begin
            rdata2 = wb_wdata;
        end else if (re2) begin
            rdata2 = regs[raddr2];
        end
    end

    // HI/LO read with bypass of the value being committed.
    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (!rst) begin
            hi_o = '0;
            lo_o = '0;
        end else if (wb_whilo) begin
            hi_o = wb_hi;
            lo_o = wb_lo;
        end else begin
            hi_o = hi_q;
            lo_o = lo_q;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: vector table through a scoreboard queue,
// plus hand sequences for reset, mid-write reset and counter wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] retire_cnt;
    logic        cnt_clr;

    logic [31:0] s_rdata1;
    logic [31:0] s_rdata2;
    logic [31:0] s_hi;
    logic [31:0] s_lo;
    logic [3:0]  s_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o),
        .retire_cnt(retire_cnt), .cnt_clr(cnt_clr)
    );

    // Narrow counter instance sharing the same bus, for the wrap check.
    wb_regfile #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .re1(re1), .raddr1(raddr1), .rdata1(s_rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(s_rdata2),
        .hi_o(s_hi), .lo_o(s_lo),
        .retire_cnt(s_cnt), .cnt_clr(cnt_clr)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        r1;
        logic [4:0]  a1;
        logic        r2;
        logic [4:0]  a2;
        logic        clr;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic [31:0] ecnt;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];
    vec_t exp_q [$];

    function automatic vec_t mk(
        logic we, logic [4:0] wd, logic [31:0] wdata,
        logic whilo, logic [31:0] hi, logic [31:0] lo,
        logic r1, logic [4:0] a1, logic r2, logic [4:0] a2,
        logic clr, logic [31:0] e1, logic [31:0] e2,
        logic [31:0] ehi, logic [31:0] elo, logic [31:0] ecnt);
        vec_t v;
        v.we = we; v.wd = wd; v.wdata = wdata;
        v.whilo = whilo; v.hi = hi; v.lo = lo;
        v.r1 = r1; v.a1 = a1; v.r2 = r2; v.a2 = a2;
        v.clr = clr; v.e1 = e1; v.e2 = e2;
        v.ehi = ehi; v.elo = elo; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wb_wd = '0; wb_wreg = 0; wb_wdata = '0;
        wb_hi = '0; wb_lo = '0; wb_whilo = 0;
        re1 = 0; raddr1 = '0; re2 = 0; raddr2 = '0;
        cnt_clr = 0;
    endtask

    task automatic drive(input vec_t v);
        wb_wreg = v.we; wb_wd = v.wd; wb_wdata = v.wdata;
        wb_whilo = v.whilo; wb_hi = v.hi; wb_lo = v.lo;
        re1 = v.r1; raddr1 = v.a1; re2 = v.r2; raddr2 = v.a2;
        cnt_clr = v.clr;
    endtask

    initial begin
        vec_t e;
        vecs[0]  = mk(0,0,0, 0,0,0, 1,5,0,0, 0, 0,0, 0,0, 0);
        vecs[1]  = mk(1,5,32'hDEADBEEF, 0,0,0, 1,5,1,5, 0,
                      32'hDEADBEEF,32'hDEADBEEF, 0,0, 0);
        vecs[2]  = mk(0,0,0, 0,0,0, 1,5,0,5, 0,
                      32'hDEADBEEF,0, 0,0, 1);
        vecs[3]  = mk(1,7,32'h1234, 0,0,0, 1,7,1,7, 0,
                      32'h1234,32'h1234, 0,0, 1);
        vecs[4]  = mk(1,0,32'hFFFFFFFF, 0,0,0, 1,0,1,7, 0,
                      0,32'h1234, 0,0, 2);
        vecs[5]  = mk(0,0,0, 0,0,0, 1,0,1,5, 0,
                      0,32'hDEADBEEF, 0,0, 2);
        vecs[6]  = mk(1,3,32'hC, 1,32'hA,32'hB, 1,3,1,7, 0,
                      32'hC,32'h1234, 32'hA,32'hB, 2);
        vecs[7]  = mk(0,0,0, 0,32'hFF,32'hEE, 1,3,1,5, 0,
                      32'hC,32'hDEADBEEF, 32'hA,32'hB, 3);
        vecs[8]  = mk(1,3,32'h33, 0,0,0, 1,3,1,3, 0,
                      32'h33,32'h33, 32'hA,32'hB, 3);
        vecs[9]  = mk(0,0,0, 1,32'h1,32'h2, 1,3,0,0, 0,
                      32'h33,0, 32'h1,32'h2, 4);
        vecs[10] = mk(1,8,32'h88, 0,0,0, 1,8,0,0, 1,
                      32'h88,0, 32'h1,32'h2, 5);
        vecs[11] = mk(0,0,0, 0,0,0, 1,8,1,7, 0,
                      32'h88,32'h1234, 32'h1,32'h2, 0);
        vecs[12] = mk(0,0,0, 0,0,0, 1,8,0,0, 0,
                      32'h88,0, 32'h1,32'h2, 0);
        vecs[13] = mk(0,0,0, 0,0,0, 0,0,1,8, 0,
                      0,32'h88, 32'h1,32'h2, 0);
        vecs[14] = mk(1,10,32'hAA, 0,0,0, 0,10,0,0, 0,
                      0,0, 32'h1,32'h2, 0);
        vecs[15] = mk(0,0,0, 0,0,0, 1,10,0,0, 0,
                      32'hAA,0, 32'h1,32'h2, 1);

        // Held in reset with live enables: everything reads zero.
        rst = 0;
        idle();
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 7;
        wb_wreg = 1; wb_wd = 7; wb_wdata = 32'h77;
        wb_whilo = 1; wb_hi = 32'h11; wb_lo = 32'h22;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_rd1", rdata1, 0);
        chk("rst_rd2", rdata2, 0);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_cnt", retire_cnt, 0);
        @(negedge clk);
        idle();
        rst = 1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("v%0d_rd1", i), rdata1, e.e1);
            chk($sformatf("v%0d_rd2", i), rdata2, e.e2);
            chk($sformatf("v%0d_hi", i), hi_o, e.ehi);
            chk($sformatf("v%0d_lo", i), lo_o, e.elo);
            chk($sformatf("v%0d_cnt", i), retire_cnt, e.ecnt);
        end

        // Asynchronous reset between edges.
        @(negedge clk);
        idle();
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 8;
        wb_whilo = 1; wb_hi = 32'h7; wb_lo = 32'h8;
        #1;
        chk("pre_rst_hi", hi_o, 32'h7);
        chk("pre_rst_rd1", rdata1, 32'hDEADBEEF);
        rst = 0;
        #1;
        chk("async_rd1", rdata1, 0);
        chk("async_rd2", rdata2, 0);
        chk("async_hi", hi_o, 0);
        chk("async_lo", lo_o, 0);
        chk("async_cnt", retire_cnt, 0);

        // Write presented while in reset is lost.
        wb_whilo = 0;
        wb_wreg = 1; wb_wd = 9; wb_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        idle();
        re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 5;
        #1;
        chk("midw_r9", rdata1, 0);
        chk("midw_r5", rdata2, 0);
        chk("midw_hi", hi_o, 0);
        chk("midw_cnt", retire_cnt, 0);

        // First edge after release commits.
        re1 = 0;
        wb_wreg = 1; wb_wd = 9; wb_wdata = 32'h55;
        @(negedge clk);
        idle();
        re1 = 1; raddr1 = 9;
        #1;
        chk("post_r9", rdata1, 32'h55);
        chk("post_r9_s", s_rdata1, 32'h55);
        chk("post_cnt", retire_cnt, 1);

        // Narrow counter wraps from all-ones to zero.
        wb_whilo = 1; wb_hi = 32'h5; wb_lo = 32'h6;
        repeat (14) @(posedge clk);
        @(negedge clk);
        wb_whilo = 0;
        #1;
        chk("cnt15", retire_cnt, 15);
        chk("s_cnt15", {28'd0, s_cnt}, 15);
        chk("s_hi", s_hi, 32'h5);
        chk("s_lo", s_lo, 32'h6);
        wb_whilo = 1;
        @(negedge clk);
        wb_whilo = 0;
        #1;
        chk("cnt16", retire_cnt, 16);
        chk("s_wrap", {28'd0, s_cnt}, 0);
        chk("s_rd2", s_rdata2, 0);

        // Clear wins over a commit in the same cycle.
        wb_whilo = 1; cnt_clr = 1;
        @(negedge clk);
        idle();
        #1;
        chk("clr_cnt", retire_cnt, 0);
        chk("clr_s_cnt", {28'd0, s_cnt}, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back sink for the MIPS pipeline. Consumes the MEM/WB register outputs and commits them to architectural state:
  - the 32x32 general-purpose register file;
  - the HI/LO register pair.
- Serves two GPR read ports and one HI/LO read port to the decode and execute stages.
- Same-cycle write-to-read bypass, so a register written in WB is seen by ID in that cycle.
- A retirement counter is exposed for debug and performance monitoring.

Parameters:
- NUM_REGS, 32, number of GPRs; r0 is hardwired to zero.
- CNT_W, 32, width of the retirement counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- wb_wd  input  5  GPR write address from MEM/WB.
- wb_wreg  input  1  GPR write enable.
- wb_wdata  input  32  GPR write data.
- wb_hi  input  32  HI write data.
- wb_lo  input  32  LO write data.
- wb_whilo  input  1  HI/LO write enable (writes both).
- re1  input  1  read port 1 enable.
- raddr1  input  5  read port 1 address.
- rdata1  output  32  read port 1 data (combinational).
- re2  input  1  read port 2 enable.
- raddr2  input  5  read port 2 address.
- rdata2  output  32  read port 2 data (combinational).
- hi_o  output  32  current HI value, bypassed.
- lo_o  output  32  current LO value, bypassed.
- retire_cnt  output  CNT_W  count of cycles in which a GPR or HI/LO commit occurred.
- cnt_clr  input  1  synchronous clear of retire_cnt.

Behaviour:
- Reset, taken immediately on rst falling and independent of clk:
  - all GPRs, HI, LO and retire_cnt clear to 0;
  - while rst=0, rdata1, rdata2, hi_o and lo_o drive 0, and no write takes effect.
- GPR write: on the rising edge with rst=1, wb_wreg=1 and wb_wd!=0, regs[wb_wd] <= wb_wdata.
  - A write to address 0 is discarded; r0 always reads 0.
- HI/LO write: on the rising edge with rst=1 and wb_whilo=1, HI <= wb_hi and LO <= wb_lo.
  - A GPR write and a HI/LO write in the same cycle both commit.
- Read port n (n=1,2), evaluated combinationally in priority order:
  1. rst=0 -> 0
  2. raddrn=0 -> 0
  3. ren=1 and wb_wreg=1 and raddrn==wb_wd -> wb_wdata (bypass)
  4. ren=1 -> regs[raddrn]
  5. ren=0 -> 0
- Both ports may read the same address and receive identical data, including the bypassed value.
- hi_o/lo_o:
  - wb_whilo=1 -> wb_hi/wb_lo (bypass);
  - otherwise the stored HI/LO;
  - 0 while in reset.
- Latency:
  - write-to-read through the bypass: 0 cycles;
  - write-to-storage: 1 edge.
- retire_cnt, per rising edge with rst=1:
  - cnt_clr=1 -> 0 (clear wins over any increment that cycle);
  - else if (wb_wreg=1 and wb_wd!=0) or wb_whilo=1 -> retire_cnt + 1, incremented once even if both commit;
  - else hold.
  - Wraps modulo 2^CNT_W from all-ones to 0 with no saturation or flag.
- A bubble inserted by MEM/WB (wb_wreg=0, wb_whilo=0, wb_wd=0) changes no state and does not count.
- Reset asserted mid-operation: any write pending on that edge is lost. After rst rises, the first edge with enables set commits normally.
- Unknown/X on the enables while rst=0 has no effect on state.

Test Plan:
- Reset: drive rst=0 between clock edges -> rdata1, rdata2, hi_o, lo_o and retire_cnt read 0 immediately. After release, reading r5 with re1=1 -> 0.
- Write then read:
  - wb_wreg=1, wb_wd=5, wb_wdata=32'hDEADBEEF for one edge, then deassert.
  - re1=1, raddr1=5 -> rdata1=32'hDEADBEEF; retire_cnt=1.
- Bypass and r0:
  - Same cycle: wb_wreg=1, wb_wd=7, wb_wdata=32'h1234; raddr1=raddr2=7 -> both ports read 32'h1234 before the edge.
  - wb_wd=0, wb_wdata=32'hFFFF_FFFF -> r0 reads 0 afterwards; retire_cnt unchanged.
- HI/LO with simultaneous GPR write:
  - wb_whilo=1, wb_hi=32'hA, wb_lo=32'hB, plus wb_wreg=1, wb_wd=3, wb_wdata=32'hC.
  - hi_o=A and lo_o=B in the same cycle; after the edge r3=C; retire_cnt increments by exactly 1.
- Counter boundary:
  - Preload retire_cnt to 32'hFFFF_FFFF via 2^32-1 commits, or use a forced/hierarchical preload in simulation; then commit once -> 0.
  - Assert cnt_clr together with a commit -> retire_cnt=0.
- Reset mid-write: drive rst=0 at the same time wb_wreg=1, wb_wd=9, wb_wdata=32'h55 -> after release r9=0 and retire_cnt=0.
